viterbi_frame_ctrl: RTL and testbench



---
 rtl/viterbi_ctrl_pkg.sv | 35 +++
 rtl/viterbi_prbs7.sv | 45 ++++
 rtl/viterbi_frame_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_viterbi_frame_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_ctrl_pkg.sv
// viterbi_ctrl_pkg
// Shared definitions for the Viterbi test-datapath frame sequencer:
//   - state_e       : frame sequencer states
//   - PRBS7_SEED    : reload value for both PRBS7 generators
//   - PRBS7_TAPS    : feedback taps for x^7 + x^6 + 1
//   - CNT_W         : width of the error / injection counters
//   - sat_add()     : saturating add used by both counters
package viterbi_ctrl_pkg;

  // Frame sequencer states, in the order a frame walks through them.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TX    = 2'd1,
    ST_TAIL  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // PRBS7 generator constants. The feedback bit is the XOR of the tapped
  // register bits (positions 7 and 6 of the polynomial, i.e. bits 6 and 5).
  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;

  // Counter width for bit_err_ct_o and inj_ct_o.
  localparam int CNT_W = 16;

  // Saturating add: the carry-out of a one-bit-wider sum tells us
  // whether to clamp at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] val,
                                               input logic [CNT_W-1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, val} + {1'b0, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/viterbi_prbs7.sv
// viterbi_prbs7
// Fibonacci PRBS7 generator (x^7 + x^6 + 1). The current output bit is the
// register MSB; advancing shifts left and inserts the feedback bit at the LSB.
// Ports:
//   clk   in  : clock
//   rst   in  : synchronous active-high reset (register returns to the seed)
//   load  in  : reload the seed on the next edge (wins over adv)
//   adv   in  : step the sequence on the next edge
//   bit_o out : current PRBS bit
module viterbi_prbs7
  import viterbi_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic adv,
  output logic bit_o
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;

  // Next-state: a reload restarts the sequence from the seed so the tx and
  // rx generators line up at the start of every frame.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = PRBS7_SEED;
    end else if (adv) begin
      lfsr_d = {lfsr_q[5:0], ^(lfsr_q & PRBS7_TAPS)};
    end
  end

  // Shift register; reset lands on the seed, never on the all-zero lockup state.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= PRBS7_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_o = lfsr_q[6];

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl
// Frame-level sequencer for the convolutional encoder -> noisy channel ->
// Viterbi decoder test datapath. A start request sends one frame of PRBS7
// data plus zero tail bits into the encoder, flips channel symbols in periodic
// bursts, and compares the decoded stream with a regenerated PRBS7 reference.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   start_i         : frame request, honoured only while idle
//   err_en_i        : error-injection enable, latched with the start
//   enc_en_o        : encoder enable (data then tail bits)
//   enc_bit_o       : encoder data bit (PRBS during data, 0 during tail)
//   enc_valid_i     : encoder produced a channel symbol this cycle
//   flip_o          : XOR mask applied by the channel to the current symbol
//   dec_en_o        : decoder enable, enc_valid_i delayed one cycle
//   dec_bit_i       : decoded bit from the Viterbi decoder
//   busy_o          : frame in progress
//   done_o          : one-cycle pulse on the last cycle of the frame
//   bit_err_ct_o    : decoded-bit mismatches in the compare window
//   inj_ct_o        : channel bits flipped (two per flipped symbol)
module viterbi_frame_ctrl
  import viterbi_ctrl_pkg::*;
#(
  parameter int FRAME_LEN  = 256,
  parameter int TAIL       = 2,
  parameter int DEC_LAT    = 64,
  parameter int ERR_PERIOD = 32,
  parameter int BURST      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             err_en_i,
  output logic             enc_en_o,
  output logic             enc_bit_o,
  input  logic             enc_valid_i,
  output logic [1:0]       flip_o,
  output logic             dec_en_o,
  input  logic             dec_bit_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] bit_err_ct_o,
  output logic [CNT_W-1:0] inj_ct_o
);

  // The whole frame is timed by one tick counter that reads 0 on the first
  // TX cycle. Every phase boundary is a fixed tick value.
  localparam int END_TICK = DEC_LAT + FRAME_LEN;
  localparam int TICK_W   = $clog2(END_TICK + 1);
  localparam int PH_W     = (ERR_PERIOD > 1) ? $clog2(ERR_PERIOD) : 1;

  localparam logic [TICK_W-1:0] TX_LAST   = TICK_W'(FRAME_LEN - 1);
  localparam logic [TICK_W-1:0] TAIL_LAST = TICK_W'(FRAME_LEN + TAIL - 1);
  localparam logic [TICK_W-1:0] WIN_FIRST = TICK_W'(DEC_LAT);
  localparam logic [TICK_W-1:0] WIN_LAST  = TICK_W'(END_TICK - 1);
  localparam logic [TICK_W-1:0] DONE_TICK = TICK_W'(END_TICK);

  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(ERR_PERIOD - 1);
  localparam logic [PH_W-1:0] PH_BTAIL = PH_W'(BURST - 1);

  state_e            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              seen_q, seen_d;
  logic              inj_en_q, inj_en_d;
  logic              dec_en_q, dec_en_d;
  logic [CNT_W-1:0]  bit_err_ct_q, bit_err_ct_d;
  logic [CNT_W-1:0]  inj_ct_q, inj_ct_d;

  logic start_acc;
  logic frame_end;
  logic busy;
  logic in_win;
  logic is_flip;
  logic tx_bit;
  logic rx_bit;

  // Transmit-side PRBS: reseeded on an accepted start, stepped on each data bit.
  viterbi_prbs7 u_tx_prbs (
    .clk   (clk),
    .rst   (rst),
    .load  (start_acc),
    .adv   (state_q == ST_TX),
    .bit_o (tx_bit)
  );

  // Receive-side PRBS: the same sequence, stepped only inside the compare
  // window so it lines up with the decoder output DEC_LAT cycles later.
  viterbi_prbs7 u_rx_prbs (
    .clk   (clk),
    .rst   (rst),
    .load  (start_acc),
    .adv   (in_win),
    .bit_o (rx_bit)
  );

  // Status decodes shared by the FSM and datapath. The tick counter is left
  // at its last value while idle, so the window test is qualified by busy.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    in_win    = busy && (tick_q >= WIN_FIRST) && (tick_q <= WIN_LAST);
    frame_end = (state_q == ST_DRAIN) && (tick_q == DONE_TICK);
  end

  // Next-state logic. DEC_LAT >= TAIL guarantees DRAIN is entered no later
  // than the done tick, so the frame always closes from DRAIN.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          start_acc = 1'b1;
          state_d   = ST_TX;
        end
      end
      ST_TX: begin
        if (tick_q == TX_LAST) begin
          state_d = (TAIL == 0) ? ST_DRAIN : ST_TAIL;
        end
      end
      ST_TAIL: begin
        if (tick_q == TAIL_LAST) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (frame_end) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Burst scheduler. Rather than keep a full symbol index and a modulo, a
  // phase counter wraps at ERR_PERIOD. A sticky flag records that the first
  // burst start (index ERR_PERIOD-1) has gone by, which gates the
  // wrapped-around part of each burst.
  always_comb begin
    is_flip = inj_en_q && busy && enc_valid_i &&
              ((phase_q == PH_LAST) || (seen_q && (phase_q < PH_BTAIL)));
  end

  // Frame datapath: tick counter, symbol phase, latched injection enable and
  // the two saturating counters. An accepted start clears everything for the
  // new frame. Counters otherwise hold, which keeps the final counts visible
  // after done until the next start.
  always_comb begin
    tick_d       = tick_q;
    phase_d      = phase_q;
    seen_d       = seen_q;
    inj_en_d     = inj_en_q;
    bit_err_ct_d = bit_err_ct_q;
    inj_ct_d     = inj_ct_q;
    dec_en_d     = enc_valid_i;

    if (start_acc) begin
      tick_d       = '0;
      phase_d      = '0;
      seen_d       = 1'b0;
      inj_en_d     = err_en_i;
      bit_err_ct_d = '0;
      inj_ct_d     = '0;
    end else begin
      if (busy && !frame_end) begin
        tick_d = tick_q + 1'b1;
      end
      if (busy && enc_valid_i) begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          seen_d  = 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      if (is_flip) begin
        inj_ct_d = sat_add(inj_ct_q, CNT_W'(2));
      end
      if (in_win && (dec_bit_i ^ rx_bit)) begin
        bit_err_ct_d = sat_add(bit_err_ct_q, CNT_W'(1));
      end
    end
  end

  // State and datapath registers. Reset returns straight to idle with every
  // output-driving flop cleared, so an aborted frame never produces done_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tick_q       <= '0;
      phase_q      <= '0;
      seen_q       <= 1'b0;
      inj_en_q     <= 1'b0;
      dec_en_q     <= 1'b0;
      bit_err_ct_q <= '0;
      inj_ct_q     <= '0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      phase_q      <= phase_d;
      seen_q       <= seen_d;
      inj_en_q     <= inj_en_d;
      dec_en_q     <= dec_en_d;
      bit_err_ct_q <= bit_err_ct_d;
      inj_ct_q     <= inj_ct_d;
    end
  end

  // Output decode. flip_o stays combinational so the channel can XOR it into
  // the symbol on the same edge that registers that symbol.
  always_comb begin
    enc_en_o     = (state_q == ST_TX) || (state_q == ST_TAIL);
    enc_bit_o    = (state_q == ST_TX) && tx_bit;
    flip_o       = {2{is_flip}};
    dec_en_o     = dec_en_q;
    busy_o       = busy;
    done_o       = frame_end;
    bit_err_ct_o = bit_err_ct_q;
    inj_ct_o     = inj_ct_q;
  end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb_viterbi_frame_ctrl
// Directed-plus-random bench for viterbi_frame_ctrl. A negedge environment
// process plays the encoder (valid one cycle after enable) and an ideal
// decoder (data bit delayed DEC_LAT cycles, optionally inverted per compare
// bit). The main initial block runs frames and compares what was observed
// against values computed here from the frame rules.
module tb_viterbi_frame_ctrl;

  localparam int FL = 256;
  localparam int TL = 2;
  localparam int DL = 64;
  localparam int EP = 32;
  localparam int BU = 2;

  typedef struct {
    bit b;
    int ord;
  } hist_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        err_en_i;
  logic        enc_valid_i = 1'b0;
  logic        dec_bit_i = 1'b0;
  logic        enc_en_o;
  logic        enc_bit_o;
  logic [1:0]  flip_o;
  logic        dec_en_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] bit_err_ct_o;
  logic [15:0] inj_ct_o;

  int vectors = 0;
  int miscompares = 0;

  // Environment bookkeeping, filled by the negedge process.
  int    cyc = 0;
  int    en_run = 0;
  int    en_cycles = 0;
  int    tail_bad = 0;
  int    dec_en_bad = 0;
  int    ord;
  bit    en_prev = 1'b0;
  bit    valid_prev = 1'b0;
  bit    busy_prev = 1'b0;
  bit    inv_mask[FL];
  bit    ref_bits[FL];
  bit    tx_bits[$];
  int    flips[$];
  int    done_cyc[$];
  int    en_rise[$];
  int    busy_rise[$];
  int    busy_fall[$];
  hist_t hist[$];
  hist_t h;

  always #5 clk = ~clk;

  viterbi_frame_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .err_en_i     (err_en_i),
    .enc_en_o     (enc_en_o),
    .enc_bit_o    (enc_bit_o),
    .enc_valid_i  (enc_valid_i),
    .flip_o       (flip_o),
    .dec_en_o     (dec_en_o),
    .dec_bit_i    (dec_bit_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .bit_err_ct_o (bit_err_ct_o),
    .inj_ct_o     (inj_ct_o)
  );

  // Encoder/decoder environment: records this cycle's outputs, then drives
  // enc_valid_i (enable delayed one cycle) and dec_bit_i (data delayed DL).
  always @(negedge clk) begin
    cyc++;
    if (done_o === 1'b1) done_cyc.push_back(cyc);
    if (busy_o === 1'b1 && !busy_prev) busy_rise.push_back(cyc);
    if (busy_o !== 1'b1 && busy_prev) busy_fall.push_back(cyc);
    busy_prev = (busy_o === 1'b1);
    ord = -1;
    if (enc_en_o === 1'b1) begin
      if (!en_prev) begin
        en_rise.push_back(cyc);
        en_run = 0;
      end
      en_cycles++;
      if (en_run < FL) begin
        ord = en_run;
        tx_bits.push_back(enc_bit_o);
      end else if (enc_bit_o !== 1'b0) begin
        tail_bad++;
      end
      en_run++;
    end
    if (rst !== 1'b1 && dec_en_o !== valid_prev) dec_en_bad++;
    while (hist.size() < DL) hist.push_back('{b: 1'b0, ord: -1});
    h.b   = enc_bit_o;
    h.ord = ord;
    hist.push_back(h);
    h = hist.pop_front();
    dec_bit_i   = h.b ^ ((h.ord >= 0) && inv_mask[h.ord]);
    enc_valid_i = en_prev;
    valid_prev  = en_prev;
    en_prev     = (enc_en_o === 1'b1);
    #1;
    if (enc_valid_i) flips.push_back(int'(flip_o));
  end

  // One comparison: counted, and reported with tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #2;
  endtask

  // Expected channel mask for symbol idx under the burst rule.
  function automatic int expFlip(input bit en, input int idx);
    if (en && idx >= EP - 1 && ((idx % EP) >= EP - 1 || (idx % EP) < BU - 1)) return 3;
    return 0;
  endfunction

  // Clears records, then holds start_i for hold_cycles cycles; t is the
  // cycle whose closing edge first samples the start.
  task automatic applyStimulus(input bit err_en, input int hold_cycles, output int t);
    nextCycle();
    tx_bits.delete();
    flips.delete();
    done_cyc.delete();
    en_rise.delete();
    busy_rise.delete();
    busy_fall.delete();
    en_cycles  = 0;
    tail_bad   = 0;
    dec_en_bad = 0;
    err_en_i   = err_en;
    start_i    = 1'b1;
    t          = cyc;
    repeat (hold_cycles) nextCycle();
    start_i = 1'b0;
  endtask

  // Waits (bounded) for done, then checks timing, counters and streams.
  task automatic checkFrame(input int t, input bit err_en, input string name);
    int exp_err;
    int exp_inj;
    int bad;
    for (int i = 0; i < 400 && done_cyc.size() == 0; i++) nextCycle();
    checkOutput({name, "_done_seen"}, done_cyc.size(), 1);
    checkOutput({name, "_done_cycle"}, (done_cyc.size() > 0) ? done_cyc[0] : -1, t + 1 + DL + FL);
    exp_err = 0;
    for (int i = 0; i < FL; i++) exp_err += int'(inv_mask[i]);
    checkOutput({name, "_bit_err_ct"}, longint'(bit_err_ct_o), exp_err);
    exp_inj = 0;
    bad = 0;
    for (int i = 0; i < flips.size(); i++) begin
      if (flips[i] != expFlip(err_en, i)) bad++;
      if (expFlip(err_en, i) != 0) exp_inj += 2;
    end
    checkOutput({name, "_inj_ct"}, longint'(inj_ct_o), exp_inj);
    checkOutput({name, "_flip_pattern"}, bad, 0);
    checkOutput({name, "_symbols"}, flips.size(), FL + TL);
    bad = 0;
    for (int i = 0; i < tx_bits.size() && i < FL; i++) if (tx_bits[i] != ref_bits[i]) bad++;
    checkOutput({name, "_prbs_bits"}, bad, 0);
    checkOutput({name, "_enc_cycles"}, en_cycles, FL + TL);
    checkOutput({name, "_tail_zero"}, tail_bad, 0);
    checkOutput({name, "_enc_start"}, (en_rise.size() > 0) ? en_rise[0] : -1, t + 1);
    checkOutput({name, "_busy_start"}, (busy_rise.size() > 0) ? busy_rise[0] : -1, t + 1);
    checkOutput({name, "_dec_en"}, dec_en_bad, 0);
    nextCycle();
    checkOutput({name, "_busy_drop"}, (busy_fall.size() > 0) ? busy_fall[0] : -1, t + 2 + DL + FL);
    checkOutput({name, "_hold_err"}, longint'(bit_err_ct_o), exp_err);
    checkOutput({name, "_hold_inj"}, longint'(inj_ct_o), exp_inj);
  endtask

  initial begin
    int t;
    int s;
    int bad;
    bit aborted[$];

    // Reference PRBS7 (x^7+x^6+1, seed 7F), MSB first.
    s = 'h7F;
    for (int k = 0; k < FL; k++) begin
      ref_bits[k] = bit'((s >> 6) & 1);
      s = ((s << 1) | (((s >> 6) ^ (s >> 5)) & 1)) & 'h7F;
    end
    for (int i = 0; i < FL; i++) inv_mask[i] = 1'b0;

    rst = 1'b1;
    start_i = 1'b0;
    err_en_i = 1'b0;
    repeat (3) nextCycle();
    checkOutput("reset_ctrl_outputs",
                longint'({enc_en_o, enc_bit_o, flip_o, dec_en_o, busy_o, done_o}), 0);
    checkOutput("reset_bit_err_ct", longint'(bit_err_ct_o), 0);
    checkOutput("reset_inj_ct", longint'(inj_ct_o), 0);
    rst = 1'b0;
    nextCycle();

    $display("[TB] frame 1: ideal decoder, no injection");
    applyStimulus(1'b0, 1, t);
    checkFrame(t, 1'b0, "f1");

    $display("[TB] frame 2: ideal decoder, injection on");
    applyStimulus(1'b1, 1, t);
    checkFrame(t, 1'b1, "f2");
    checkOutput("f2_inj_total", longint'(inj_ct_o), 32);

    $display("[TB] frame 3: compare bit 100 inverted");
    inv_mask[100] = 1'b1;
    applyStimulus(1'b0, 1, t);
    checkFrame(t, 1'b0, "f3");

    $display("[TB] frame 4: all compare bits inverted, injection on");
    for (int i = 0; i < FL; i++) inv_mask[i] = 1'b1;
    applyStimulus(1'b1, 1, t);
    checkFrame(t, 1'b1, "f4");
    checkOutput("f4_err_total", longint'(bit_err_ct_o), 256);

    for (int r = 0; r < 3; r++) begin
      bit en;
      $display("[TB] random frame %0d", r);
      for (int i = 0; i < FL; i++) inv_mask[i] = ($urandom_range(7) == 0);
      en = bit'($urandom_range(1));
      applyStimulus(en, 1, t);
      checkFrame(t, en, $sformatf("rnd%0d", r));
    end

    $display("[TB] start held high for 400 cycles");
    for (int i = 0; i < FL; i++) inv_mask[i] = 1'b0;
    applyStimulus(1'b0, 400, t);
    while (cyc < t + 700) nextCycle();
    checkOutput("hold_done_count", done_cyc.size(), 2);
    checkOutput("hold_done_first", (done_cyc.size() > 0) ? done_cyc[0] : -1, t + 321);
    checkOutput("hold_done_second", (done_cyc.size() > 1) ? done_cyc[1] : -1, t + 643);
    checkOutput("hold_frame_count", en_rise.size(), 2);
    checkOutput("hold_second_start", (en_rise.size() > 1) ? en_rise[1] : -1, t + 323);

    $display("[TB] reset at cycle 50 of a frame");
    applyStimulus(1'b1, 1, t);
    while (cyc < t + 50) nextCycle();
    rst = 1'b1;
    nextCycle();
    checkOutput("abort_ctrl_outputs",
                longint'({enc_en_o, enc_bit_o, flip_o, dec_en_o, busy_o, done_o}), 0);
    checkOutput("abort_bit_err_ct", longint'(bit_err_ct_o), 0);
    checkOutput("abort_inj_ct", longint'(inj_ct_o), 0);
    rst = 1'b0;
    aborted = tx_bits;
    checkOutput("abort_bits_sent", aborted.size(), 50);
    repeat (400) nextCycle();
    checkOutput("abort_no_done", done_cyc.size(), 0);

    applyStimulus(1'b1, 1, t);
    checkFrame(t, 1'b1, "restart");
    bad = 0;
    for (int i = 0; i < aborted.size() && i < tx_bits.size(); i++) if (aborted[i] != tx_bits[i]) bad++;
    checkOutput("restart_same_bits", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
